rs232_avm_scheduler: RTL and testbench

Avalon-MM master that owns the RS232 UART slave and shares its single bus port between two clients. The receive client assembles multi-byte frames such as 32-bit coordinates. The transmit client sends single bytes, such as game events, back to the host. The block sequences STATUS polls, RX reads and TX writes, and arbitrates round-robin when both directions are ready. It sits between the UART Avalon slave and the game logic.

---
 rtl/rs232_avm_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_rs232_avm_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_scheduler.sv
// Avalon-MM master for the RS232 UART: polls STATUS, reads RX bytes into frames,
// writes single TX bytes, round-robin between directions. Optional: RS232_FRAME_TIMEOUT_EN.
module rs232_avm_scheduler #(
    parameter int unsigned RX_BASE        = 0,
    parameter int unsigned TX_BASE        = 4,
    parameter int unsigned STATUS_BASE    = 8,
    parameter int unsigned RX_OK_BIT      = 7,
    parameter int unsigned TX_OK_BIT      = 6,
    parameter int unsigned FRAME_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic [31:0] rx_word,
    output logic        rx_word_valid,
    output logic        frame_drop
);

    localparam logic [31:0] FRAME_MASK = (FRAME_BYTES >= 4) ? 32'hFFFF_FFFF
                                         : ((32'd1 << (8 * FRAME_BYTES)) - 32'd1);
    localparam logic [1:0]  LAST_COUNT = 2'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_POLL,
        S_RX,
        S_TX
    } state_t;

    state_t      state, state_nx;
    logic        rr, rr_nx;
    logic [4:0]  addr_nx;
    logic        read_nx, write_nx;
    logic [31:0] wdata_nx;
    logic        rx_take, tx_done;
    logic        rx_ok, tx_go;
    logic        tx_full;
    logic [7:0]  tx_byte;
    logic [1:0]  count;
    logic [23:0] shift;
    logic [31:0] frame_word;
    logic        frame_last;
    logic        timeout_hit;
    logic        unused_bits;

    assign tx_ready    = ~tx_full;
    assign rx_ok       = avm_readdata[RX_OK_BIT];
    assign tx_go       = avm_readdata[TX_OK_BIT] & tx_full;
    assign frame_word  = {shift, avm_readdata[7:0]} & FRAME_MASK;
    assign frame_last  = rx_take && (count == LAST_COUNT);
    assign unused_bits = ^{avm_readdata, 32'(TIMEOUT_CYCLES)};

    // Bus signals change only on a completion cycle, so they stay put under waitrequest.
    always_comb begin
        state_nx = state;
        rr_nx    = rr;
        addr_nx  = avm_address;
        read_nx  = avm_read;
        write_nx = avm_write;
        wdata_nx = avm_writedata;
        rx_take  = 1'b0;
        tx_done  = 1'b0;
        if (!avm_waitrequest) begin
            case (state)
                S_POLL: begin
                    if (rx_ok && (!tx_go || !rr)) begin
                        state_nx = S_RX;
                        rr_nx    = 1'b1;
                    end else if (tx_go) begin
                        state_nx = S_TX;
                        rr_nx    = 1'b0;
                    end
                end
                S_RX: begin
                    rx_take  = 1'b1;
                    state_nx = S_POLL;
                end
                S_TX: begin
                    tx_done  = 1'b1;
                    state_nx = S_POLL;
                end
                default: state_nx = S_POLL;
            endcase

            case (state_nx)
                S_RX: begin
                    addr_nx  = 5'(RX_BASE);
                    read_nx  = 1'b1;
                    write_nx = 1'b0;
                    wdata_nx = '0;
                end
                S_TX: begin
                    addr_nx  = 5'(TX_BASE);
                    read_nx  = 1'b0;
                    write_nx = 1'b1;
                    wdata_nx = {24'b0, tx_byte};
                end
                default: begin
                    addr_nx  = 5'(STATUS_BASE);
                    read_nx  = 1'b1;
                    write_nx = 1'b0;
                    wdata_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state         <= S_POLL;
            rr            <= 1'b0;
            avm_address   <= 5'(STATUS_BASE);
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            state         <= state_nx;
            rr            <= rr_nx;
            avm_address   <= addr_nx;
            avm_read      <= read_nx;
            avm_write     <= write_nx;
            avm_writedata <= wdata_nx;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            tx_full <= 1'b0;
            tx_byte <= '0;
        end else if (tx_done) begin
            tx_full <= 1'b0;
        end else if (tx_valid && !tx_full) begin
            tx_full <= 1'b1;
            tx_byte <= tx_data;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            count         <= '0;
            shift         <= '0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
        end else begin
            rx_word_valid <= 1'b0;
            if (rx_take) begin
                shift <= {shift[15:0], avm_readdata[7:0]};
                if (frame_last) begin
                    rx_word       <= frame_word;
                    rx_word_valid <= 1'b1;
                    count         <= '0;
                end else begin
                    count <= count + 2'd1;
                end
            end else if (timeout_hit) begin
                count <= '0;
                shift <= '0;
            end
        end
    end

`ifdef RS232_FRAME_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [IDLE_W-1:0] idle_cnt;

    // An arriving byte takes priority over an expiring timeout.
    assign timeout_hit = !rx_take && (count != '0) &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            idle_cnt   <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= timeout_hit;
            if (rx_take || (count == '0) || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_drop  = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_avm_scheduler.sv
// Self-checking bench for rs232_avm_scheduler: UART slave model plus RX/TX scoreboards.
module tb_rs232_avm_scheduler;

`ifdef RS232_FRAME_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1000000;
`endif

    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic        frame_drop;

    rs232_avm_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .rx_word         (rx_word),
        .rx_word_valid   (rx_word_valid),
        .frame_drop      (frame_drop)
    );

    always #5 avm_clk = ~avm_clk;

    int          checks = 0;
    int          errors = 0;
    int          drop_cnt = 0;
    logic [7:0]  rx_list[$];
    logic [31:0] rx_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int          grant_log[$];
    logic        rx_en = 1'b0;
    logic        tx_free = 1'b0;
    logic        rx_done_now = 1'b0;
    logic        after_xfer = 1'b0;
    logic        tx_done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and scoreboard consumer, sampled mid-cycle when everything is settled.
    always @(negedge avm_clk) begin
        logic [31:0] st;
        #2;
        rx_done_now = 1'b0;
        if (!avm_rst) begin
            chk("rw_exclusive", 32'(avm_read & avm_write), 0);
            if (after_xfer) begin
                chk("poll_after_xfer_addr", 32'(avm_address), 8);
                chk("poll_after_xfer_rw", 32'({avm_read, avm_write}), 2);
            end
            if (tx_done_prev)
                chk("tx_ready_back", 32'(tx_ready), 1);
            after_xfer   = 1'b0;
            tx_done_prev = 1'b0;
            if (!avm_waitrequest) begin
                if (avm_read && avm_address == 5'd0) begin
                    rx_done_now = 1'b1;
                    after_xfer  = 1'b1;
                    grant_log.push_back(0);
                end
                if (avm_write) begin
                    after_xfer   = 1'b1;
                    tx_done_prev = 1'b1;
                    grant_log.push_back(1);
                    chk("tx_addr", 32'(avm_address), 4);
                    chk("tx_expected", 32'(tx_exp_q.size() > 0), 1);
                    if (tx_exp_q.size() > 0)
                        chk("tx_writedata", avm_writedata, {24'b0, tx_exp_q.pop_front()});
                end
            end
            if (rx_word_valid) begin
                chk("rx_expected", 32'(rx_exp_q.size() > 0), 1);
                if (rx_exp_q.size() > 0)
                    chk("rx_word", rx_word, rx_exp_q.pop_front());
            end
            if (frame_drop)
                drop_cnt++;
        end else begin
            after_xfer   = 1'b0;
            tx_done_prev = 1'b0;
        end
        st = (32'(rx_en && rx_list.size() != 0) << 7) | (32'(tx_free) << 6);
        if (avm_address == 5'd8)
            avm_readdata = st;
        else if (avm_address == 5'd0 && rx_list.size() > 0)
            avm_readdata = {24'b0, rx_list[0]};
        else
            avm_readdata = 32'h0;
    end

    always @(posedge avm_clk)
        if (rx_done_now && rx_list.size() > 0)
            void'(rx_list.pop_front());

    task automatic step(input int n);
        repeat (n) @(negedge avm_clk);
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        rx_list.push_back(b0);
        rx_list.push_back(b1);
        rx_list.push_back(b2);
        rx_list.push_back(b3);
        rx_exp_q.push_back({b0, b1, b2, b3});
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < 200), 1);
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 100) begin
            step(1);
            n++;
        end
        chk("tx_accept_wait", 32'(n < 100), 1);
        tx_exp_q.push_back(b);
        step(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        int n;
        avm_rst         = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        step(3);
        chk("rst_address", 32'(avm_address), 8);
        chk("rst_read", 32'(avm_read), 1);
        chk("rst_write", 32'(avm_write), 0);
        chk("rst_writedata", avm_writedata, 0);
        chk("rst_rx_word", rx_word, 0);
        chk("rst_rx_word_valid", 32'(rx_word_valid), 0);
        chk("rst_frame_drop", 32'(frame_drop), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        avm_rst = 1'b0;

        // Idle status: back-to-back status reads only
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("idle_poll_addr", 32'(avm_address), 8);
            chk("idle_poll_rw", 32'({avm_read, avm_write}), 2);
        end
        chk("idle_tx_ready", 32'(tx_ready), 1);

        // One RX frame, MSB first
        push_frame(8'h12, 8'h34, 8'h56, 8'h78);
        rx_en = 1'b1;
        wait_drain("frame1_drain");
        step(10);
        chk("rx_word_hold", rx_word, 32'h12345678);

        // Single TX byte
        tx_free = 1'b1;
        chk("tx_ready_pre", 32'(tx_ready), 1);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tx_exp_q.push_back(8'hA5);
        step(1);
        tx_valid = 1'b0;
        chk("tx_ready_drop", 32'(tx_ready), 0);
        wait_drain("tx_drain");
        step(2);
        chk("tx_ready_idle", 32'(tx_ready), 1);

        // Stall the first RX read for 5 cycles
        push_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        n = 0;
        while (!(avm_read && avm_address == 5'd0) && n < 20) begin
            step(1);
            n++;
        end
        chk("stall_rx_seen", 32'(n < 20), 1);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_addr", 32'(avm_address), 0);
            chk("stall_rw", 32'({avm_read, avm_write}), 2);
        end
        avm_waitrequest = 1'b0;
        wait_drain("stall_drain");
        chk("stall_rx_word", rx_word, 32'hDEADBEEF);

        // Round-robin from reset: RX and TX become ready together
        avm_rst = 1'b1;
        step(2);
        avm_rst = 1'b0;
        chk("rst2_rx_word", rx_word, 0);
        rx_en   = 1'b0;
        tx_free = 1'b0;
        send_tx(8'h5A);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        grant_log.delete();
        rx_en   = 1'b1;
        tx_free = 1'b1;
        send_tx(8'h5B);
        send_tx(8'h5C);
        send_tx(8'h5D);
        wait_drain("rr_drain");
        step(4);
        chk("rr_len", 32'(grant_log.size()), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("rr_grant", 32'(grant_log[i]), 32'(i % 2));

        // Reset during a stalled write drops the pending byte
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        step(1);
        tx_valid = 1'b0;
        n = 0;
        while (!avm_write && n < 20) begin
            step(1);
            n++;
        end
        chk("abort_write_seen", 32'(n < 20), 1);
        avm_waitrequest = 1'b1;
        step(2);
        avm_rst = 1'b1;
        step(1);
        avm_waitrequest = 1'b0;
        step(1);
        avm_rst = 1'b0;
        chk("abort_write", 32'(avm_write), 0);
        chk("abort_addr", 32'(avm_address), 8);
        chk("abort_tx_ready", 32'(tx_ready), 1);
        step(10);

`ifdef RS232_FRAME_TIMEOUT_EN
        // Partial frame times out, then the stream resyncs
        rx_list.push_back(8'hAA);
        rx_list.push_back(8'hBB);
        n = 0;
        while (drop_cnt == 0 && n < 60) begin
            step(1);
            n++;
        end
        chk("frame_drop_seen", 32'(drop_cnt), 1);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        wait_drain("resync_drain");
        chk("resync_rx_word", rx_word, 32'h01020304);
        chk("frame_drop_once", 32'(drop_cnt), 1);
`else
        chk("frame_drop_tied", 32'(drop_cnt), 0);
`endif

        chk("rx_q_empty", 32'(rx_exp_q.size()), 0);
        chk("tx_q_empty", 32'(tx_exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
